// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop add two WIDTH-bit
// operands LSB first. Optional macro SERIAL_ADDER_OVF_EN adds the OVF output.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] a_shift;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_s;
  logic             bit_c;
  logic             accept;
  logic             last;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | ((x ^ y) & ci);
  endfunction

  assign bit_s  = fa_sum(op_a[0], op_b[0], carry);
  assign bit_c  = fa_carry(op_a[0], op_b[0], carry);
  assign last   = (cnt == LAST);
  assign accept = START && (state != SHIFT);

  // The result bits enter op_a at the MSB as its operand bits leave at the LSB,
  // so op_a doubles as the result shift register.
  if (WIDTH > 1) begin : g_wide
    assign a_shift = {bit_s, op_a[WIDTH-1:1]};
  end else begin : g_one
    assign a_shift = bit_s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = FIN;
      FIN:     state_nxt = START ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY = (state == SHIFT);
  assign DONE = (state == FIN);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      SUM   <= '0;
      Cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      OVF   <= 1'b0;
`endif
    end else if (accept) begin
      op_a  <= A;
      op_b  <= B;
      carry <= Cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      op_a  <= a_shift;
      op_b  <= op_b >> 1;
      carry <= bit_c;
      cnt   <= cnt + CNT_W'(1);
      if (last) begin
        SUM  <= a_shift;
        Cout <= bit_c;
`ifdef SERIAL_ADDER_OVF_EN
        // carry still holds the carry into the MSB on the last step
        OVF  <= carry ^ bit_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 1 and 16 against an
// arithmetic reference model; checks OVF when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a_bus = '0;
  logic [15:0] b_bus = '0;
  logic        cin = 1'b0;
  int          sel = 0;

  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        busy1, done1, cout1, ovf1;
  logic [0:0]  sum1;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic        start8, start1, start16;
  logic        busy_s, done_s, cout_s, ovf_s;
  logic [15:0] sum_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  assign start8  = start && (sel == 0);
  assign start1  = start && (sel == 1);
  assign start16 = start && (sel == 2);

  serial_adder #(.WIDTH(8)) u_dut8 (
    .CLK(CLK), .RST(RST), .START(start8), .A(a_bus[7:0]), .B(b_bus[7:0]), .Cin(cin),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .Cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .OVF(ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .START(start1), .A(a_bus[0:0]), .B(b_bus[0:0]), .Cin(cin),
    .BUSY(busy1), .DONE(done1), .SUM(sum1), .Cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .OVF(ovf1)
`endif
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .CLK(CLK), .RST(RST), .START(start16), .A(a_bus), .B(b_bus), .Cin(cin),
    .BUSY(busy16), .DONE(done16), .SUM(sum16), .Cout(cout16)
`ifdef SERIAL_ADDER_OVF_EN
    , .OVF(ovf16)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf1  = 1'b0;
  assign ovf16 = 1'b0;
`endif

  always_comb begin
    busy_s = busy8;
    done_s = done8;
    cout_s = cout8;
    ovf_s  = ovf8;
    sum_s  = {8'h00, sum8};
    if (sel == 1) begin
      busy_s = busy1;
      done_s = done1;
      cout_s = cout1;
      ovf_s  = ovf1;
      sum_s  = {15'h0000, sum1};
    end else if (sel == 2) begin
      busy_s = busy16;
      done_s = done16;
      cout_s = cout16;
      ovf_s  = ovf16;
      sum_s  = sum16;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int s);
    return (s == 0) ? 8 : (s == 1) ? 1 : 16;
  endfunction

  // One addition on the selected instance; expected result from plain arithmetic.
  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input string tag);
    int     w, lat, nbusy;
    longint m, ua, ub, tot, half, sa, sb, st;
    logic   exp_cout, exp_ovf;
    w    = width_of(s);
    m    = (longint'(1) << w) - 1;
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    tot  = ua + ub + longint'(c);
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    st   = sa + sb + longint'(c);
    exp_cout = ((tot >> w) & 1) != 0;
    exp_ovf  = (st >= half) || (st < -half);

    sel = s;
    @(negedge CLK);
    a_bus = a; b_bus = b; cin = c; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    lat = 1;
    nbusy = 0;
    while (!done_s && lat < 40) begin
      if (busy_s) nbusy++;
      @(negedge CLK);
      lat++;
    end
    check_val({tag, ":done"}, 64'(done_s), 64'd1);
    check_val({tag, ":latency"}, 64'(lat), 64'(w + 1));
    check_val({tag, ":busy_cycles"}, 64'(nbusy), 64'(w));
    check_val({tag, ":busy_at_done"}, 64'(busy_s), 64'd0);
    check_val({tag, ":sum"}, 64'(sum_s), 64'(tot & m));
    check_val({tag, ":cout"}, 64'(cout_s), 64'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
    check_val({tag, ":ovf"}, 64'(ovf_s), 64'(exp_ovf));
`else
    if (exp_ovf && ovf_s) n_vec += 0;
`endif
    @(negedge CLK);
    check_val({tag, ":done_pulse"}, 64'(done_s), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation bound expired, observed running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, t1, t2, ndone, dlat;
    logic [15:0] got_sum;

    repeat (3) @(negedge CLK);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_val("rst:busy", 64'(busy_s), 64'd0);
      check_val("rst:done", 64'(done_s), 64'd0);
      check_val("rst:sum", 64'(sum_s), 64'd0);
      check_val("rst:cout", 64'(cout_s), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check_val("rst:ovf", 64'(ovf_s), 64'd0);
`endif
    end
    sel = 0;
    @(negedge CLK);
    RST = 1'b0;

    run_op(0, 16'h00FF, 16'h0001, 1'b0, "ff_plus_01");
    run_op(0, 16'h005A, 16'h003C, 1'b1, "5a_plus_3c");

    // Back-to-back with START held: operands changed during BUSY feed the second add.
    sel = 0;
    @(negedge CLK);
    a_bus = 16'h005A; b_bus = 16'h003C; cin = 1'b1; start = 1'b1;
    @(negedge CLK);
    a_bus = 16'h00FF; b_bus = 16'h00FF; cin = 1'b1;
    lat = 1; t1 = 0; t2 = 0;
    while (t2 == 0 && lat < 40) begin
      if (done_s) begin
        if (t1 == 0) begin
          t1 = lat;
          check_val("b2b:sum1", 64'(sum_s), 64'h97);
          check_val("b2b:cout1", 64'(cout_s), 64'd0);
        end else begin
          t2 = lat;
          check_val("b2b:sum2", 64'(sum_s), 64'hFF);
          check_val("b2b:cout2", 64'(cout_s), 64'd1);
          start = 1'b0;
        end
      end
      if (t2 == 0) begin
        @(negedge CLK);
        lat++;
      end
    end
    start = 1'b0;
    check_val("b2b:first_latency", 64'(t1), 64'd9);
    check_val("b2b:spacing", 64'(t2 - t1), 64'd9);
    @(negedge CLK);
    check_val("b2b:idle_after", 64'(done_s), 64'd0);

    // START pulses and operand changes while BUSY must be ignored.
    @(negedge CLK);
    a_bus = 16'h0012; b_bus = 16'h0034; cin = 1'b0; start = 1'b1;
    @(negedge CLK);
    ndone = 0; dlat = 0; got_sum = '0;
    for (int i = 1; i <= 20; i++) begin
      if (done_s) begin
        ndone++;
        dlat = i;
        got_sum = sum_s;
      end
      start = (i == 2) || (i == 5);
      if (i == 2) a_bus = 16'h0000;
      @(negedge CLK);
    end
    start = 1'b0;
    check_val("ignore:done_count", 64'(ndone), 64'd1);
    check_val("ignore:latency", 64'(dlat), 64'd9);
    check_val("ignore:sum", 64'(got_sum), 64'h46);

    // Reset during the 4th SHIFT cycle discards the addition.
    @(negedge CLK);
    a_bus = 16'h0077; b_bus = 16'h0011; cin = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_val("midrst:busy", 64'(busy_s), 64'd0);
    check_val("midrst:done", 64'(done_s), 64'd0);
    check_val("midrst:sum", 64'(sum_s), 64'd0);
    check_val("midrst:cout", 64'(cout_s), 64'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_s || busy_s) ndone++;
      @(negedge CLK);
    end
    check_val("midrst:quiet", 64'(ndone), 64'd0);
    run_op(0, 16'h0010, 16'h0020, 1'b0, "after_rst");

    // RST beats a simultaneous START.
    RST = 1'b1; start = 1'b1;
    @(negedge CLK);
    RST = 1'b0; start = 1'b0;
    check_val("rst_start:busy", 64'(busy_s), 64'd0);
    @(negedge CLK);
    check_val("rst_start:busy2", 64'(busy_s), 64'd0);

    run_op(0, 16'h007F, 16'h0001, 1'b0, "ovf_7f_01");
    run_op(0, 16'h0080, 16'h00FF, 1'b0, "ovf_80_ff");
    run_op(0, 16'h0010, 16'h0020, 1'b0, "ovf_10_20");

    run_op(1, 16'h0001, 16'h0001, 1'b1, "w1_111");
    run_op(1, 16'h0001, 16'h0000, 1'b0, "w1_100");
    run_op(1, 16'h0000, 16'h0000, 1'b1, "w1_001");

    run_op(2, 16'hFFFF, 16'hFFFF, 1'b1, "w16_max");
    run_op(2, 16'h0000, 16'h0000, 1'b0, "w16_zero");
    run_op(2, 16'h7FFF, 16'h0000, 1'b1, "w16_ovf");
    for (int i = 0; i < 1000; i++) begin
      run_op(2, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
             1'($urandom_range(0, 1)), "w16_rand");
    end
    for (int i = 0; i < 40; i++) begin
      run_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), "w8_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
